// File: rtl/ahb_fir_pkg.sv
// Shared AHB-Lite types, widths and instruction-word field layout for the instruction master.
// The instruction word is packed as {HWRITE, HSIZE, HTRANS, addr, wdata}.
package ahb_fir_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned AWIDTH = 32;
    localparam int unsigned IW     = DWIDTH + AWIDTH + 6;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // Bit offsets of each field inside the packed instruction word.
    localparam int unsigned DATA_LSB   = 0;
    localparam int unsigned ADDR_LSB   = DWIDTH;
    localparam int unsigned HTRANS_LSB = DWIDTH + AWIDTH;
    localparam int unsigned HSIZE_LSB  = HTRANS_LSB + 2;
    localparam int unsigned HWRITE_BIT = HSIZE_LSB + 3;

    typedef struct packed {
        logic              hwrite;
        logic [2:0]        hsize;
        htrans_t           htrans;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } ahb_instr_t;

    // Only NONSEQ and SEQ transfers own a data phase.
    function automatic logic has_data_phase(htrans_t t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_instr_unpack.sv
// Splits a packed instruction word into its AHB fields; purely combinational.
// Shared by the master and by any monitor that needs to decode driver words.
module ahb_instr_unpack
    import ahb_fir_pkg::*;
(
    input  logic [IW-1:0] instr_i,
    output ahb_instr_t    instr_o
);

    always_comb begin
        instr_o.hwrite = instr_i[HWRITE_BIT];
        instr_o.hsize  = instr_i[HSIZE_LSB +: 3];
        instr_o.htrans = htrans_t'(instr_i[HTRANS_LSB +: 2]);
        instr_o.addr   = instr_i[ADDR_LSB +: AWIDTH];
        instr_o.data   = instr_i[DATA_LSB +: DWIDTH];
    end

endmodule

// File: rtl/ahb_instr_master.sv
// AHB-Lite master: turns driver instruction words into pipelined transfers (stage A = address
// phase, stage D = data phase) and returns completed reads as a one-cycle {addr, data} flag.
module ahb_instr_master
    import ahb_fir_pkg::*;
#(
    parameter int unsigned DWIDTH = ahb_fir_pkg::DWIDTH,
    parameter int unsigned AWIDTH = ahb_fir_pkg::AWIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         amba_en,
    input  logic [DWIDTH+AWIDTH+6-1:0]   amba_instr,
    output logic                         instr_rd,
    output logic                         amba_wr_flg,
    output logic [AWIDTH-1:0]            amba_slv_addr,
    output logic [DWIDTH-1:0]            amba_slv_data,
    output logic [AWIDTH-1:0]            HADDR,
    output logic [1:0]                   HTRANS,
    output logic                         HWRITE,
    output logic [2:0]                   HSIZE,
    output logic [DWIDTH-1:0]            HWDATA,
    input  logic [DWIDTH-1:0]            HRDATA,
    input  logic                         HREADY,
    input  logic                         HRESP
);

    ahb_instr_t instr;

    ahb_instr_unpack u_unpack (
        .instr_i (amba_instr),
        .instr_o (instr)
    );

    // Stage A: address phase
    logic              a_valid_q, a_valid_d;
    ahb_instr_t        a_q, a_d;

    // Stage D: data phase
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [AWIDTH-1:0] d_addr_q, d_addr_d;
    logic [DWIDTH-1:0] hwdata_q, hwdata_d;

    logic              err_hold_q, err_hold_d;

    // Read-return register
    logic              flg_q, flg_d;
    logic [AWIDTH-1:0] slv_addr_q, slv_addr_d;
    logic [DWIDTH-1:0] slv_data_q, slv_data_d;

    logic advance;
    logic accept;
    logic d_done;
    logic err_start;
    logic err_end;

    always_comb begin
        advance   = HREADY & ~err_hold_q;
        accept    = amba_en & (~a_valid_q | advance);
        d_done    = d_valid_q & HREADY & ~HRESP;
        err_start = d_valid_q & HRESP & ~HREADY & ~err_hold_q;
        err_end   = err_hold_q & HREADY;
    end

    // A loads on accept; otherwise it empties once its address phase is taken.
    always_comb begin
        a_valid_d = a_valid_q;
        a_d       = a_q;
        if (accept) begin
            a_valid_d = 1'b1;
            a_d       = instr;
        end else if (advance) begin
            a_valid_d = 1'b0;
        end
    end

    // D is refilled from A on advance; an errored transfer is dropped when the error response ends.
    always_comb begin
        d_valid_d = d_valid_q;
        d_write_d = d_write_q;
        d_addr_d  = d_addr_q;
        hwdata_d  = hwdata_q;
        if (advance) begin
            d_valid_d = a_valid_q & has_data_phase(a_q.htrans);
            if (a_valid_q && has_data_phase(a_q.htrans)) begin
                d_write_d = a_q.hwrite;
                d_addr_d  = a_q.addr;
                hwdata_d  = a_q.data;
            end
        end else if (err_end) begin
            d_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_hold_d = err_hold_q;
        if (err_start) begin
            err_hold_d = 1'b1;
        end else if (err_end) begin
            err_hold_d = 1'b0;
        end
    end

    always_comb begin
        flg_d      = d_done & ~d_write_q & ~err_hold_q;
        slv_addr_d = slv_addr_q;
        slv_data_d = slv_data_q;
        if (flg_d) begin
            slv_addr_d = d_addr_q;
            slv_data_d = HRDATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_q        <= '0;
            d_valid_q  <= 1'b0;
            d_write_q  <= 1'b0;
            d_addr_q   <= '0;
            hwdata_q   <= '0;
            err_hold_q <= 1'b0;
            flg_q      <= 1'b0;
            slv_addr_q <= '0;
            slv_data_q <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_q        <= a_d;
            d_valid_q  <= d_valid_d;
            d_write_q  <= d_write_d;
            d_addr_q   <= d_addr_d;
            hwdata_q   <= hwdata_d;
            err_hold_q <= err_hold_d;
            flg_q      <= flg_d;
            slv_addr_q <= slv_addr_d;
            slv_data_q <= slv_data_d;
        end
    end

    // While an error response is in progress the pending address phase is cancelled.
    always_comb begin
        HTRANS = (a_valid_q && !err_hold_q) ? a_q.htrans : IDLE;
        HADDR  = a_q.addr;
        HWRITE = a_q.hwrite;
        HSIZE  = a_q.hsize;
        HWDATA = hwdata_q;
    end

    assign instr_rd      = accept;
    assign amba_wr_flg   = flg_q;
    assign amba_slv_addr = slv_addr_q;
    assign amba_slv_data = slv_data_q;

endmodule

// File: tb/tb_ahb_instr_master.sv
// Directed self-checking bench for ahb_instr_master: writes, reads, stalls, error response,
// IDLE words and asynchronous reset in mid-transfer.
module tb_ahb_instr_master;
    import ahb_fir_pkg::*;

    logic              clk;
    logic              rst;
    logic              amba_en;
    logic [IW-1:0]     amba_instr;
    logic              instr_rd;
    logic              amba_wr_flg;
    logic [AWIDTH-1:0] amba_slv_addr;
    logic [DWIDTH-1:0] amba_slv_data;
    logic [AWIDTH-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DWIDTH-1:0] HWDATA;
    logic [DWIDTH-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;
    ahb_instr_t        mon;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    ahb_instr_master dut (
        .clk           (clk),
        .rst           (rst),
        .amba_en       (amba_en),
        .amba_instr    (amba_instr),
        .instr_rd      (instr_rd),
        .amba_wr_flg   (amba_wr_flg),
        .amba_slv_addr (amba_slv_addr),
        .amba_slv_data (amba_slv_data),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HWDATA        (HWDATA),
        .HRDATA        (HRDATA),
        .HREADY        (HREADY),
        .HRESP         (HRESP)
    );

    ahb_instr_unpack u_mon (
        .instr_i (amba_instr),
        .instr_o (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [IW-1:0] mk(input logic w, input logic [2:0] sz,
                                         input logic [1:0] tr, input logic [31:0] a,
                                         input logic [31:0] d);
        return {w, sz, tr, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        amba_en    = 1'b0;
        amba_instr = '0;
        HRDATA     = '0;
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        #2;
        chk("rst_htrans", 64'(HTRANS), 64'h0);
        chk("rst_haddr", 64'(HADDR), 64'h0);
        chk("rst_hwdata", 64'(HWDATA), 64'h0);
        chk("rst_hsize", 64'(HSIZE), 64'h0);
        chk("rst_hwrite", 64'(HWRITE), 64'h0);
        chk("rst_flg", 64'(amba_wr_flg), 64'h0);
        chk("rst_slv_addr", 64'(amba_slv_addr), 64'h0);
        chk("rst_slv_data", 64'(amba_slv_data), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single write
        amba_en    = 1'b1;
        amba_instr = mk(1'b1, 3'b010, 2'b10, 32'h10, 32'hDEADBEEF);
        #1;
        chk("t1_instr_rd", 64'(instr_rd), 64'h1);
        chk("t1_mon_addr", 64'(mon.addr), 64'h10);
        tick();
        amba_en = 1'b0;
        #1;
        chk("t1_haddr", 64'(HADDR), 64'h10);
        chk("t1_htrans", 64'(HTRANS), 64'h2);
        chk("t1_hwrite", 64'(HWRITE), 64'h1);
        chk("t1_hsize", 64'(HSIZE), 64'h2);
        chk("t1_instr_rd_idle", 64'(instr_rd), 64'h0);
        tick();
        chk("t1_hwdata", 64'(HWDATA), 64'hDEADBEEF);
        chk("t1_htrans_idle", 64'(HTRANS), 64'h0);
        chk("t1_flg_a", 64'(amba_wr_flg), 64'h0);
        tick();
        chk("t1_flg_b", 64'(amba_wr_flg), 64'h0);

        // 2: single read
        amba_en    = 1'b1;
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h14, 32'h0);
        HRDATA     = 32'h5;
        tick();
        amba_en = 1'b0;
        chk("t2_haddr", 64'(HADDR), 64'h14);
        chk("t2_hwrite", 64'(HWRITE), 64'h0);
        tick();
        chk("t2_flg_early", 64'(amba_wr_flg), 64'h0);
        tick();
        chk("t2_flg", 64'(amba_wr_flg), 64'h1);
        chk("t2_slv_addr", 64'(amba_slv_addr), 64'h14);
        chk("t2_slv_data", 64'(amba_slv_data), 64'h5);
        tick();
        chk("t2_flg_one_cycle", 64'(amba_wr_flg), 64'h0);

        // 3: three back-to-back reads, 2-cycle stall in the second data phase
        amba_en    = 1'b1;
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h30, 32'h0);
        tick();
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h34, 32'h0);
        #1;
        chk("t3_rd_pipelined", 64'(instr_rd), 64'h1);
        tick();
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h38, 32'h0);
        HRDATA     = 32'hA30;
        tick();
        chk("t3_flg0", 64'(amba_wr_flg), 64'h1);
        chk("t3_addr0", 64'(amba_slv_addr), 64'h30);
        chk("t3_data0", 64'(amba_slv_data), 64'hA30);
        chk("t3_haddr_pre", 64'(HADDR), 64'h38);
        HREADY     = 1'b0;
        HRDATA     = 32'hBAD;
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h3C, 32'h0);
        #1;
        chk("t3_instr_rd_stall", 64'(instr_rd), 64'h0);
        amba_en = 1'b0;
        tick();
        chk("t3_flg_stall", 64'(amba_wr_flg), 64'h0);
        chk("t3_haddr_stall1", 64'(HADDR), 64'h38);
        chk("t3_htrans_stall1", 64'(HTRANS), 64'h2);
        tick();
        chk("t3_haddr_stall2", 64'(HADDR), 64'h38);
        chk("t3_flg_stall2", 64'(amba_wr_flg), 64'h0);
        HREADY = 1'b1;
        HRDATA = 32'hA34;
        tick();
        chk("t3_flg1", 64'(amba_wr_flg), 64'h1);
        chk("t3_addr1", 64'(amba_slv_addr), 64'h34);
        chk("t3_data1", 64'(amba_slv_data), 64'hA34);
        chk("t3_htrans_drain", 64'(HTRANS), 64'h0);
        HRDATA = 32'hA38;
        tick();
        chk("t3_flg2", 64'(amba_wr_flg), 64'h1);
        chk("t3_addr2", 64'(amba_slv_addr), 64'h38);
        chk("t3_data2", 64'(amba_slv_data), 64'hA38);
        tick();
        chk("t3_flg_end", 64'(amba_wr_flg), 64'h0);

        // 4: error on write 0x20 while read 0x24 sits in the address phase
        amba_en    = 1'b1;
        amba_instr = mk(1'b1, 3'b010, 2'b10, 32'h20, 32'h11111111);
        tick();
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h24, 32'h0);
        tick();
        amba_en = 1'b0;
        HRESP   = 1'b1;
        HREADY  = 1'b0;
        tick();
        chk("t4_htrans_err2", 64'(HTRANS), 64'h0);
        HREADY = 1'b1;
        tick();
        HRESP  = 1'b0;
        HRDATA = 32'h24024;
        chk("t4_reissue_htrans", 64'(HTRANS), 64'h2);
        chk("t4_reissue_haddr", 64'(HADDR), 64'h24);
        chk("t4_no_flg_a", 64'(amba_wr_flg), 64'h0);
        tick();
        chk("t4_no_flg_b", 64'(amba_wr_flg), 64'h0);
        tick();
        chk("t4_flg", 64'(amba_wr_flg), 64'h1);
        chk("t4_addr", 64'(amba_slv_addr), 64'h24);
        chk("t4_data", 64'(amba_slv_data), 64'h24024);
        tick();
        chk("t4_flg_end", 64'(amba_wr_flg), 64'h0);

        // 5: IDLE word between two writes
        amba_en    = 1'b1;
        amba_instr = mk(1'b1, 3'b010, 2'b10, 32'h40, 32'hAA);
        tick();
        amba_instr = mk(1'b0, 3'b010, 2'b00, 32'h99, 32'h0);
        #1;
        chk("t5_idle_consumed", 64'(instr_rd), 64'h1);
        tick();
        chk("t5_htrans_idle", 64'(HTRANS), 64'h0);
        chk("t5_hwdata0", 64'(HWDATA), 64'hAA);
        amba_instr = mk(1'b1, 3'b010, 2'b10, 32'h44, 32'hBB);
        tick();
        amba_en = 1'b0;
        chk("t5_htrans_w2", 64'(HTRANS), 64'h2);
        chk("t5_haddr_w2", 64'(HADDR), 64'h44);
        chk("t5_hwdata_no_idle_phase", 64'(HWDATA), 64'hAA);
        tick();
        chk("t5_hwdata1", 64'(HWDATA), 64'hBB);
        chk("t5_htrans_end", 64'(HTRANS), 64'h0);
        chk("t5_flg", 64'(amba_wr_flg), 64'h0);

        // 6: asynchronous reset during a stalled read
        amba_en    = 1'b1;
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h50, 32'h0);
        tick();
        amba_en = 1'b0;
        tick();
        HREADY = 1'b0;
        HRDATA = 32'h50;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_async_htrans", 64'(HTRANS), 64'h0);
        chk("t6_async_haddr", 64'(HADDR), 64'h0);
        chk("t6_async_flg", 64'(amba_wr_flg), 64'h0);
        HREADY = 1'b1;
        tick();
        chk("t6_flg_in_rst", 64'(amba_wr_flg), 64'h0);
        rst = 1'b0;
        tick();
        chk("t6_flg_after_rst", 64'(amba_wr_flg), 64'h0);
        amba_en    = 1'b1;
        amba_instr = mk(1'b0, 3'b010, 2'b10, 32'h54, 32'h0);
        HRDATA     = 32'h77;
        tick();
        amba_en = 1'b0;
        chk("t6_haddr", 64'(HADDR), 64'h54);
        tick();
        tick();
        chk("t6_flg", 64'(amba_wr_flg), 64'h1);
        chk("t6_addr", 64'(amba_slv_addr), 64'h54);
        chk("t6_data", 64'(amba_slv_data), 64'h77);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
